// File: rtl/uart_stdout_tx.sv
// rtl/uart_stdout_tx.sv - buffered 8N1 UART transmitter for the stdout path
//
// Purpose:
//   Accepts bytes from the core stdout write port and queues them in a small
//   byte FIFO. It serializes them onto the Tx line as 8N1 frames: one start bit,
//   eight data bits LSB first, and one stop bit. Every line bit lasts
//   DIV = CLOCK_RATE / BAUD_RATE clock cycles. Queued bytes go out back-to-back
//   with no idle gap between frames.
//
// Ports:
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   wr_valid_i    in   byte write request
//   wr_data_i     in   byte to transmit
//   wr_ready_o    out  FIFO can accept a byte (not full)
//   tx_o          out  registered serial line, idle high
//   busy_o        out  a frame is on the line or bytes are queued
//   fifo_level_o  out  current FIFO occupancy
//   frame_done_o  out  one-cycle pulse on the final stop-bit cycle
module uart_stdout_tx #(
  parameter int CLOCK_RATE = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_valid_i,
  input  logic [7:0]                       wr_data_i,
  output logic                             wr_ready_o,
  output logic                             tx_o,
  output logic                             busy_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level_o,
  output logic                             frame_done_o
);

  localparam int DIV = CLOCK_RATE / BAUD_RATE;
  // The guard keeps the counter width legal so the divisor check below can report.
  localparam int CW  = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int LW  = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  generate
    if (DIV < 2) begin : g_div_check
      $error("uart_stdout_tx: CLOCK_RATE / BAUD_RATE must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
      $error("uart_stdout_tx: FIFO_DEPTH must be a power of two and at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Byte FIFO. The pointers wrap naturally. Full and empty come only from the
  // occupancy counter, so the pointers never need an extra wrap bit.
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  assign fifo_empty   = (level == '0);
  // A full FIFO refuses writes even if a pop occurs on the same edge. There is
  // no bypass, so readiness depends only on registered state.
  assign wr_ready_o   = (level != LVL_FULL);
  assign push         = wr_valid_i && wr_ready_o;
  assign fifo_level_o = level;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_t        state;
  state_t        state_d;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [7:0]    shreg_d;
  logic          tx_q;
  logic          tx_d;
  logic          bit_end;

  // bit_cnt counts 0..DIV-1 inside each line bit. The last count ends the bit.
  assign bit_end = (bit_cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic. The FSM is the only reader of the FIFO. The pop at the
  // end of STOP moves straight into the next START, so frames stay contiguous.
  always_comb begin
    state_d = state;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end && bit_idx == 3'd7) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic. The line level is computed for the state being entered and
  // is registered in tx_q. The pin then changes exactly on the bit boundary
  // without glitching.
  always_comb begin
    shreg_d = shreg;
    if (pop) begin
      shreg_d = mem[rd_ptr];
    end else if (state == S_DATA && bit_end) begin
      shreg_d = {1'b0, shreg[7:1]};
    end

    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase

    frame_done_o = (state == S_STOP) && bit_end;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
    end else begin
      // The counter is held at 0 in IDLE, so START always gets a full DIV cycles.
      if (state == S_IDLE || bit_end) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + CW'(1);
      end

      if (pop) begin
        bit_idx <= '0;
      end else if (state == S_DATA && bit_end) begin
        bit_idx <= bit_idx + 3'd1;
      end

      shreg <= shreg_d;
      tx_q  <= tx_d;
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = (state != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_stdout_tx.sv
// tb/tb_uart_stdout_tx.sv - self-checking bench for uart_stdout_tx
module tb_uart_stdout_tx;

  localparam int CLOCK_RATE = 16;
  localparam int BAUD_RATE  = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV        = CLOCK_RATE / BAUD_RATE;
  localparam int FRAME      = 10 * DIV;
  localparam int LW         = $clog2(FIFO_DEPTH + 1);

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          wr_valid = 1'b0;
  logic [7:0]    wr_data  = 8'h00;
  logic          wr_ready;
  logic          tx;
  logic          busy;
  logic [LW-1:0] fifo_level;
  logic          frame_done;

  uart_stdout_tx #(
    .CLOCK_RATE(CLOCK_RATE),
    .BAUD_RATE (BAUD_RATE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_valid_i  (wr_valid),
    .wr_data_i   (wr_data),
    .wr_ready_o  (wr_ready),
    .tx_o        (tx),
    .busy_o      (busy),
    .fifo_level_o(fifo_level),
    .frame_done_o(frame_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: bytes accepted by the handshake, in the order they must appear on the line.
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         cyc        = 0;
  int         frames     = 0;
  int         last_start = -1;
  int         fill_lvl[6] = '{1, 1, 2, 3, 4, 4};

  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: decodes 8N1 frames from tx and checks each one against the expected byte stream.
  initial begin : line_monitor
    logic [9:0] bits;
    logic [7:0] want;
    bit         steady;
    bit         aborted;
    int         fd_cnt;
    int         fd_pos;
    int         t0;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        t0 = cyc; steady = 1'b1; aborted = 1'b0; fd_cnt = 0; fd_pos = -1; bits = '0;
        for (int i = 0; i < FRAME; i++) begin
          if (i > 0) @(negedge clk);
          if (!rst_n) aborted = 1'b1;
          if (i % DIV == 0) bits[i / DIV] = tx;
          else if (tx !== bits[i / DIV]) steady = 1'b0;
          if (frame_done === 1'b1) begin
            fd_cnt++;
            fd_pos = i;
          end
        end
        if (!aborted) begin
          frames++;
          start_q.push_back(t0);
          check("start_bit", bits[0], 1'b0);
          check("stop_bit", bits[9], 1'b1);
          check("bit_steady", steady, 1'b1);
          check("done_count", fd_cnt, 1);
          check("done_pos", fd_pos, FRAME - 1);
          if (last_start >= 0) check("frame_spacing_min", (t0 - last_start) >= FRAME, 1'b1);
          last_start = t0;
          check("frame_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            check("frame_data", bits[8:1], want);
          end
        end
      end
    end
  end

  // Pushes one byte. Call it just after a negedge; it returns one negedge later.
  task automatic drive_push(input logic [7:0] b, output bit acc);
    wr_valid = 1'b1;
    wr_data  = b;
    acc      = wr_ready;
    if (acc) exp_q.push_back(b);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy, 1'b0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit acc;
    int n;
    int frames0;

    // Reset
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_hold_tx", tx, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_ready", wr_ready, 1'b1);
    check("rst_level", fifo_level, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", frame_done, 1'b0);

    // Single byte 0x41
    frames0 = frames;
    drive_push(8'h41, acc);
    check("sb_accept", acc, 1'b1);
    check("sb_level_push", fifo_level, 1);
    check("sb_tx_before_pop", tx, 1'b1);
    check("sb_busy", busy, 1'b1);
    @(negedge clk);
    check("sb_tx_start", tx, 1'b0);
    check("sb_level_pop", fifo_level, 0);
    n = 0;
    while (busy !== 1'b0 && n < FRAME + 20) begin
      @(negedge clk);
      n++;
    end
    check("sb_busy_drop", n, FRAME);
    check("sb_frames", frames - frames0, 1);

    // Fill to full: 0x01..0x06 pushed on consecutive edges
    start_q.delete();
    frames0 = frames;
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i + 1);
      acc      = wr_ready;
      if (acc) exp_q.push_back(wr_data);
      check($sformatf("fill_ready_%0d", i), acc, (i < 5));
      @(negedge clk);
      check($sformatf("fill_level_%0d", i), fifo_level, fill_lvl[i]);
    end
    wr_valid = 1'b0;
    wait_idle(6 * FRAME, "fill_drain");
    check("fill_frames", frames - frames0, 5);
    for (int i = 1; i < 5 && i < start_q.size(); i++)
      check($sformatf("fill_gap_%0d", i), start_q[i] - start_q[i-1], FRAME);

    // Simultaneous push/pop at level 2
    drive_push(8'hC3, acc);
    drive_push(8'h3C, acc);
    drive_push(8'h96, acc);
    check("sim_level_pre", fifo_level, 2);
    n = 0;
    while (frame_done !== 1'b1 && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check("sim_done_seen", frame_done, 1'b1);
    check("sim_level_at_stop", fifo_level, 2);
    drive_push(8'h69, acc);
    check("sim_accept", acc, 1'b1);
    check("sim_level_post", fifo_level, 2);
    wait_idle(4 * FRAME, "sim_drain");

    // Reset during DATA bit 3
    drive_push(8'hA5, acc);
    drive_push(8'h11, acc);
    drive_push(8'h22, acc);
    repeat (69) @(negedge clk);
    check("mid_tx_bit3", tx, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1'b1);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", wr_ready, 1'b1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME + 20) @(negedge clk);
    check("mid_idle_tx", tx, 1'b1);
    frames0 = frames;
    drive_push(8'h55, acc);
    wait_idle(FRAME + 40, "mid_drain");
    check("mid_frames", frames - frames0, 1);

    // Randomized traffic: dense bursts that overflow the FIFO, then sparse writes
    for (int k = 0; k < 2500; k++) begin
      wr_valid = ($urandom_range(0, (k < 1200) ? 2 : 150) == 0);
      wr_data  = 8'($urandom);
      if (wr_valid && wr_ready) exp_q.push_back(wr_data);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    wait_idle((FIFO_DEPTH + 2) * FRAME, "rand_drain");
    check("rand_queue_empty", exp_q.size(), 0);
    check("rand_level", fifo_level, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_stdout_tx.md
# uart_stdout_tx

Buffered 8N1 UART transmitter for the stdout path of `cv32e40p_impl_top`. It accepts bytes from the core-side stdout write port, queues them in a FIFO and serializes them onto the top-level `Tx` pin. On the bench, that pin is consumed by the `Uart8` receiver and printed. It is the stage directly upstream of the bench receiver, and its timing must match the receiver's `CLOCK_RATE`/`BAUD_RATE`.

## Interface
- `CLOCK_RATE`, default 100000000: clk frequency in Hz.
- `BAUD_RATE`, default 9600: line rate in bit/s.
- `FIFO_DEPTH`, default 16: byte FIFO entries. Must be a power of two, ≥2.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `wr_valid_i`  in  1  byte write request from the core stdout port.
- `wr_data_i`  in  8  byte to transmit.
- `wr_ready_o`  out  1  FIFO can accept a byte. Equals `!full`.
- `tx_o`  out  1  serial line. Idle high. Drives `Tx`.
- `busy_o`  out  1  high while a frame is on the line or the FIFO is non-empty.
- `fifo_level_o`  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- `frame_done_o`  out  1  one-cycle pulse on the last cycle of each stop bit.

## Operation
- **Divisor:** DIV = CLOCK_RATE / BAUD_RATE, integer truncation. DIV ≥ 2 is required; this is checked by an elaboration-time assertion. Every line bit lasts exactly DIV clk cycles.
- **Push:** occurs on any edge where `wr_valid_i && wr_ready_o`. Writes while full are dropped; `wr_ready_o` low tells the sender to hold.
- **Push and pop on the same edge:** both happen and the level is unchanged.
- **Full FIFO:** `wr_ready_o` is low even if a pop occurs on the same edge. No bypass.
- **Frame format:** start bit (0), 8 data bits LSB first, one stop bit (1). No parity.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `tx_o`=1. If the FIFO is non-empty, pop into the 8-bit shift register, clear the bit counter (DIV-1..0) and the bit index (0..7), and go to START.
  - START: `tx_o`=0 for DIV cycles, then go to DATA.
  - DATA: `tx_o`=shreg[0]. At each bit end, shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: `tx_o`=1 for DIV cycles. On the last cycle, pulse `frame_done_o`. Then:
    - if the FIFO is non-empty: pop and go directly to START, with no idle gap;
    - otherwise go to IDLE.
- **`tx_o` register:** `tx_o` comes from a flop, so there are no glitches.
- **`busy_o`:** `(state != IDLE) || (level != 0)`.
- **Pointer wrap:** FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Full and empty are derived from a separate occupancy counter.

## Timing
- **Reset values:** `tx_o`=1, `wr_ready_o`=1, `busy_o`=0, `fifo_level_o`=0, `frame_done_o`=0. State=IDLE, FIFO empty, counters 0.
- **Reset mid-frame:** `tx_o` returns to 1 immediately (asynchronous). The queued bytes and the partial frame are discarded.
- **Push-to-line latency:** a push on edge N into an empty FIFO while IDLE updates the level at N. IDLE pops at N+1. `tx_o` falls after edge N+1 and the start bit begins one cycle after the push.
- **Frame length:** exactly 10·DIV cycles. Back-to-back frames are contiguous.
- **`frame_done_o`:** high for exactly one cycle per frame, coincident with the final stop-bit cycle.
- **Defaults:** DIV=10416. A full FIFO drains in 16·104160 cycles.

## Test plan
- **Reset:** hold `rst_n`=0 for 4 cycles, release → `tx_o`=1, `wr_ready_o`=1, `fifo_level_o`=0, `busy_o`=0.
- **Single byte** (CLOCK_RATE=16, BAUD_RATE=1, DIV=16): push 0x41 → start 16 cycles low, then bits 1,0,0,0,0,0,1,0 each 16 cycles, stop 16 cycles high; `frame_done_o` pulses once; `busy_o` drops after the stop bit.
- **Fill to full** (FIFO_DEPTH=4): push 0x01..0x05 on consecutive cycles →
  - the first pop empties slot 0 early, so 5 bytes are accepted;
  - a 6th push sees `wr_ready_o`=0 and is dropped;
  - bytes appear on the line in order with no inter-frame gap (frame starts 160 cycles apart).
- **Simultaneous push/pop:** at level 2, push on the cycle STOP pops → level stays 2 and no data is lost.
- **Reset mid-frame:** assert `rst_n` during DATA bit 3 → `tx_o`=1 immediately and the FIFO is empty. A later push of 0x55 transmits a clean frame.
- **End-to-end** with default parameters, the bench `Uart8` connected and a "Hi\n" string pushed → the bench prints "Hi\n".
